banco_registradores_param: RTL and testbench

Parametrised register file with scoreboard for the processor datapath: two combinational read ports, one byte-masked synchronous write port, optional hardwired zero register, optional write-to-read forwarding, and per-register busy bits. Busy bits let the pipeline stall on operands with outstanding writes. It is the drop-in successor to the fixed 32×32 register bank between the decode stage (reads, reservations) and the write-back stage (writes).

---
 rtl/banco_registradores_param.sv | 106 ++++++++++
 tb/tb_banco_registradores_param.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/banco_registradores_param.sv
// Parametrised register file with per-register busy scoreboard: two combinational
// read ports, one byte-masked write port, optional zero register and forwarding.
module banco_registradores_param #(
  parameter int LARGURA      = 32,
  parameter int PROFUNDIDADE = 32,
  parameter bit ZERO_R0      = 1'b1,
  parameter bit BYPASS       = 1'b1,
  localparam int AW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1,
  localparam int NB = LARGURA / 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [AW-1:0]      RN,
  input  logic [AW-1:0]      RM,
  input  logic [AW-1:0]      RD,
  input  logic [LARGURA-1:0] DadoRegEscrita,
  input  logic [NB-1:0]      MascaraByte,
  input  logic               CTRLEscritaReg,
  input  logic [AW-1:0]      RDReserva,
  input  logic               CTRLReserva,
  output logic [LARGURA-1:0] DadoRegLeitura1,
  output logic [LARGURA-1:0] DadoRegLeitura2,
  output logic               Pronto1,
  output logic               Pronto2
);

  typedef struct packed {
    logic [LARGURA-1:0] data;
    logic               pronto;
  } leitura_t;

  logic [LARGURA-1:0] regs [PROFUNDIDADE];
  logic [PROFUNDIDADE-1:0] busy;
  logic [LARGURA-1:0] wr_old;
  logic [LARGURA-1:0] wr_merged;
  logic wr_eff;
  logic res_eff;
  leitura_t rp1;
  leitura_t rp2;

  // An address is live when it exists and is not the hardwired zero register.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return (int'(a) < PROFUNDIDADE) && !(ZERO_R0 && (a == '0));
  endfunction

  assign wr_eff  = CTRLEscritaReg && addr_live(RD);
  assign res_eff = CTRLReserva && addr_live(RDReserva);
  assign wr_old  = (int'(RD) < PROFUNDIDADE) ? regs[RD] : '0;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_merged = wr_old;
    for (int i = 0; i < NB; i++) begin
      if (MascaraByte[i]) wr_merged[8*i +: 8] = DadoRegEscrita[8*i +: 8];
    end
  end

  // NOTE: the array is reset on purpose: reads must return 0 as soon as RST rises,
  // so this storage maps to flops rather than a RAM macro.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < PROFUNDIDADE; i++) regs[i] <= '0;
    end else if (wr_eff) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      regs[RD] <= wr_merged;
    end
  end

  // A reservation in the same cycle as the completing write wins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < PROFUNDIDADE; i++) begin
        if (res_eff && (RDReserva == AW'(i)))  busy[i] <= 1'b1;
        else if (wr_eff && (RD == AW'(i)))     busy[i] <= 1'b0;
      end
    end
  end

  function automatic leitura_t read_port(input logic [AW-1:0] a);
    leitura_t r;
    r.data   = '0;
    r.pronto = 1'b1;
    if (addr_live(a)) begin
      if (BYPASS && wr_eff && (a == RD)) begin
        r.data = wr_merged;
      end else begin
        r.data   = regs[a];
        r.pronto = !busy[a];
      end
    end
    return r;
  endfunction

  always_comb begin
    rp1 = read_port(RN);
    rp2 = read_port(RM);
  end

  assign DadoRegLeitura1 = rp1.data;
  assign Pronto1         = rp1.pronto;
  assign DadoRegLeitura2 = rp2.data;
  assign Pronto2         = rp2.pronto;

endmodule

// File: tb/tb_banco_registradores_param.sv
// Bench for banco_registradores_param: two instances (32 regs, zero reg + forwarding;
// 24 regs, no zero reg, no forwarding) share stimulus and are checked against a model.
module tb_banco_registradores_param;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  RN, RM, RD, RDReserva;
  logic [31:0] DadoRegEscrita;
  logic [3:0]  MascaraByte;
  logic        CTRLEscritaReg, CTRLReserva;
  logic [31:0] d1 [2];
  logic [31:0] d2 [2];
  logic        p1 [2];
  logic        p2 [2];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state and per-instance configuration.
  logic [31:0] mem [2][32];
  bit          bsy [2][32];
  int          depth [2] = '{32, 24};
  bit          zr    [2] = '{1'b1, 1'b0};
  bit          bp    [2] = '{1'b1, 1'b0};

  always #5 CLK = ~CLK;

  banco_registradores_param #(.LARGURA(32), .PROFUNDIDADE(32), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut0 (
    .CLK(CLK), .RST(RST), .RN(RN), .RM(RM), .RD(RD),
    .DadoRegEscrita(DadoRegEscrita), .MascaraByte(MascaraByte), .CTRLEscritaReg(CTRLEscritaReg),
    .RDReserva(RDReserva), .CTRLReserva(CTRLReserva),
    .DadoRegLeitura1(d1[0]), .DadoRegLeitura2(d2[0]), .Pronto1(p1[0]), .Pronto2(p2[0])
  );

  banco_registradores_param #(.LARGURA(32), .PROFUNDIDADE(24), .ZERO_R0(1'b0), .BYPASS(1'b0)) dut1 (
    .CLK(CLK), .RST(RST), .RN(RN), .RM(RM), .RD(RD),
    .DadoRegEscrita(DadoRegEscrita), .MascaraByte(MascaraByte), .CTRLEscritaReg(CTRLEscritaReg),
    .RDReserva(RDReserva), .CTRLReserva(CTRLReserva),
    .DadoRegLeitura1(d1[1]), .DadoRegLeitura2(d2[1]), .Pronto1(p1[1]), .Pronto2(p2[1])
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] merge_word(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] m);
    logic [31:0] bm = 32'h0;
    for (int i = 0; i < 4; i++) if (m[i]) bm = bm | (32'hFF << (8 * i));
    return (old_w & ~bm) | (new_w & bm);
  endfunction

  function automatic bit live(int k, int a);
    return (a < depth[k]) && !(zr[k] && a == 0);
  endfunction

  function automatic bit m_wr(int k);
    return CTRLEscritaReg && live(k, int'(RD));
  endfunction

  function automatic logic [31:0] m_data(int k, int a);
    if (!live(k, a)) return 32'h0;
    if (bp[k] && m_wr(k) && int'(RD) == a) return merge_word(mem[k][a], DadoRegEscrita, MascaraByte);
    return mem[k][a];
  endfunction

  function automatic logic m_rdy(int k, int a);
    if (!live(k, a)) return 1'b1;
    if (bp[k] && m_wr(k) && int'(RD) == a) return 1'b1;
    return !bsy[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 32; a++) begin
        mem[k][a] = 32'h0;
        bsy[k][a] = 1'b0;
      end
  endtask

  task automatic model_edge();
    if (RST) return;
    for (int k = 0; k < 2; k++) begin
      bit w = m_wr(k);
      bit r = CTRLReserva && live(k, int'(RDReserva));
      if (w) begin
        mem[k][RD] = merge_word(mem[k][RD], DadoRegEscrita, MascaraByte);
        bsy[k][RD] = 1'b0;
      end
      if (r) bsy[k][RDReserva] = 1'b1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clk_edge();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic idle();
    CTRLEscritaReg = 1'b0;
    CTRLReserva    = 1'b0;
    MascaraByte    = 4'h0;
    DadoRegEscrita = 32'h0;
    RD = 5'd0;
    RDReserva = 5'd0;
  endtask

  task automatic set_write(logic [4:0] a, logic [31:0] v, logic [3:0] m);
    CTRLEscritaReg = 1'b1;
    RD = a;
    DadoRegEscrita = v;
    MascaraByte = m;
  endtask

  task automatic set_res(logic [4:0] a);
    CTRLReserva = 1'b1;
    RDReserva = a;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle(); set_write(5'd5, 32'h12345678, 4'hF); clk_edge();
    idle(); set_write(5'd31, 32'hCAFEBABE, 4'hF); set_res(5'd5); clk_edge();
    idle(); RN = 5'd5; RM = 5'd31; #1;
    n_checks++; if (d1[0] !== 32'h12345678) $display("FAIL reset_prewrite_d1: got %h want %h", d1[0], 32'h12345678); else n_pass++;
    n_checks++; if (p1[0] !== 1'b0) $display("FAIL reset_prewrite_p1: got %b want 0", p1[0]); else n_pass++;
    RST = 1'b1; model_reset(); #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (d1[k] !== 32'h0) $display("FAIL reset_d1 dut%0d: got %h want 0", k, d1[k]); else n_pass++;
      n_checks++; if (d2[k] !== 32'h0) $display("FAIL reset_d2 dut%0d: got %h want 0", k, d2[k]); else n_pass++;
      n_checks++; if (p1[k] !== 1'b1 || p2[k] !== 1'b1) $display("FAIL reset_pronto dut%0d: got %b%b want 11", k, p1[k], p2[k]); else n_pass++;
    end
    clk_edge();
    RST = 1'b0; #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (d1[k] !== 32'h0 || d2[k] !== 32'h0) $display("FAIL post_reset_data dut%0d: got %h %h want 0 0", k, d1[k], d2[k]); else n_pass++;
    end
  endtask

  task automatic test_byte_mask();
    idle(); set_write(5'd3, 32'hAABBCCDD, 4'b1111); clk_edge();
    idle(); set_write(5'd3, 32'h11223344, 4'b0101); clk_edge();
    idle(); RN = 5'd3; RM = 5'd3; #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (d1[k] !== 32'hAA22CC44) $display("FAIL byte_mask_d1 dut%0d: got %h want %h", k, d1[k], 32'hAA22CC44); else n_pass++;
      n_checks++; if (d2[k] !== 32'hAA22CC44) $display("FAIL byte_mask_d2 dut%0d: got %h want %h", k, d2[k], 32'hAA22CC44); else n_pass++;
    end
    // Zero mask: data holds, busy still clears.
    idle(); set_res(5'd3); clk_edge();
    idle(); set_write(5'd3, 32'hFFFFFFFF, 4'b0000); clk_edge();
    idle(); RN = 5'd3; #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (d1[k] !== 32'hAA22CC44 || p1[k] !== 1'b1) $display("FAIL zero_mask dut%0d: got %h/%b want %h/1", k, d1[k], p1[k], 32'hAA22CC44); else n_pass++;
    end
  endtask

  task automatic test_zero_reg();
    idle(); set_write(5'd0, 32'hFFFFFFFF, 4'hF); set_res(5'd0); clk_edge();
    idle(); RN = 5'd0; #1;
    n_checks++; if (d1[0] !== 32'h0 || p1[0] !== 1'b1) $display("FAIL zero_reg_on: got %h/%b want 0/1", d1[0], p1[0]); else n_pass++;
    n_checks++; if (d1[1] !== 32'hFFFFFFFF || p1[1] !== 1'b0) $display("FAIL zero_reg_off: got %h/%b want ffffffff/0", d1[1], p1[1]); else n_pass++;
    idle(); set_write(5'd0, 32'h0, 4'hF); clk_edge();
  endtask

  task automatic test_bypass();
    idle(); set_write(5'd7, 32'h10, 4'hF); clk_edge();
    idle(); RN = 5'd7; set_write(5'd7, 32'h99, 4'hF); #1;
    n_checks++; if (d1[0] !== 32'h99) $display("FAIL bypass_on_pre: got %h want 99", d1[0]); else n_pass++;
    n_checks++; if (d1[1] !== 32'h10) $display("FAIL bypass_off_pre: got %h want 10", d1[1]); else n_pass++;
    clk_edge(); idle(); #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (d1[k] !== 32'h99) $display("FAIL bypass_post dut%0d: got %h want 99", k, d1[k]); else n_pass++;
    end
  endtask

  task automatic test_scoreboard();
    idle(); set_res(5'd9); RN = 5'd9; #1;
    n_checks++; if (p1[0] !== 1'b1) $display("FAIL res_pre_edge: got %b want 1", p1[0]); else n_pass++;
    clk_edge(); idle(); #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (p1[k] !== 1'b0) $display("FAIL res_busy dut%0d: got %b want 0", k, p1[k]); else n_pass++;
    end
    set_write(5'd9, 32'h55, 4'hF); #1;
    n_checks++; if (p1[0] !== 1'b1) $display("FAIL clear_same_cycle: got %b want 1", p1[0]); else n_pass++;
    n_checks++; if (p1[1] !== 1'b0) $display("FAIL clear_nobypass_pre: got %b want 0", p1[1]); else n_pass++;
    clk_edge(); idle(); #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (p1[k] !== 1'b1) $display("FAIL clear_post dut%0d: got %b want 1", k, p1[k]); else n_pass++;
    end
    set_write(5'd9, 32'h66, 4'hF); set_res(5'd9); clk_edge(); idle(); #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (p1[k] !== 1'b0 || d1[k] !== 32'h66) $display("FAIL res_wins dut%0d: got %h/%b want 66/0", k, d1[k], p1[k]); else n_pass++;
    end
    set_write(5'd9, 32'h0, 4'h0); clk_edge(); idle();
  endtask

  task automatic test_out_of_range();
    idle(); set_write(5'd30, 32'hDEAD, 4'hF); set_res(5'd30); clk_edge();
    idle(); RN = 5'd30; RM = 5'd23; #1;
    n_checks++; if (d1[0] !== 32'hDEAD || p1[0] !== 1'b0) $display("FAIL oor_inrange dut0: got %h/%b want dead/0", d1[0], p1[0]); else n_pass++;
    n_checks++; if (d1[1] !== 32'h0 || p1[1] !== 1'b1) $display("FAIL oor_ignored dut1: got %h/%b want 0/1", d1[1], p1[1]); else n_pass++;
    set_res(5'd23); clk_edge(); idle(); set_res(5'd1); clk_edge(); idle(); RN = 5'd1; #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (p1[k] !== 1'b0 || p2[k] !== 1'b0) $display("FAIL busy_before_rst dut%0d: got %b%b want 00", k, p1[k], p2[k]); else n_pass++;
    end
    RST = 1'b1; model_reset(); #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (p1[k] !== 1'b1 || p2[k] !== 1'b1) $display("FAIL rst_clears_busy dut%0d: got %b%b want 11", k, p1[k], p2[k]); else n_pass++;
    end
    #3 RST = 1'b0;
    clk_edge();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      idle();
      RN = 5'($urandom_range(0, 31));
      RM = ($urandom_range(0, 3) == 0) ? RN : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) set_write(5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) set_res(5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) RD = RN;
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++; if (d1[k] !== m_data(k, int'(RN))) $display("FAIL rand_d1 dut%0d cyc%0d: got %h want %h", k, c, d1[k], m_data(k, int'(RN))); else n_pass++;
        n_checks++; if (d2[k] !== m_data(k, int'(RM))) $display("FAIL rand_d2 dut%0d cyc%0d: got %h want %h", k, c, d2[k], m_data(k, int'(RM))); else n_pass++;
        n_checks++; if (p1[k] !== m_rdy(k, int'(RN))) $display("FAIL rand_p1 dut%0d cyc%0d: got %b want %b", k, c, p1[k], m_rdy(k, int'(RN))); else n_pass++;
        n_checks++; if (p2[k] !== m_rdy(k, int'(RM))) $display("FAIL rand_p2 dut%0d cyc%0d: got %b want %b", k, c, p2[k], m_rdy(k, int'(RM))); else n_pass++;
      end
      clk_edge();
    end
  endtask

  initial begin
    RST = 1'b1; RN = 5'd0; RM = 5'd0;
    idle(); model_reset();
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    clk_edge();
    test_reset();
    test_byte_mask();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_out_of_range();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
